regfile_write_ctrl: RTL and testbench

Write-port controller for the core register file. It arbitrates between N_REQ writeback requesters (ALU, load unit, ...) and owns a busy scoreboard of pending destination registers for hazard stalls. It also generates a clean one-cycle write_enable strobe with setup-stable write_reg and write_data, because the register file commits on the rising edge of write_enable.

---
 rtl/regfile_ctrl_pkg.sv | 15 +
 rtl/regfile_write_ctrl_wb_arbiter.sv | 65 ++++++
 rtl/regfile_write_ctrl.sv | 138 +++++++++++++
 tb/tb_regfile_write_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and write-sequencer state encoding for the register-file
// write controller.
package regfile_ctrl_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2
    } wr_state_t;

endpackage

// File: rtl/regfile_write_ctrl_wb_arbiter.sv
// Writeback arbiter: combinational one-hot grant among N_REQ requesters.
// Define REGFILE_WRITE_CTRL_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module wb_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_valid,
    input  logic             enable,
    output logic [N_REQ-1:0] grant
);

    logic found;
    int   idx;

`ifdef REGFILE_WRITE_CTRL_ROUND_ROBIN_EN
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] rr_ptr_next;

    // Search starts at the pointer; the pointer only moves on an actual grant.
    always_comb begin
        grant       = '0;
        found       = 1'b0;
        idx         = 0;
        rr_ptr_next = rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                if (enable) begin
                    grant[idx]  = 1'b1;
                    rr_ptr_next = (idx == N_REQ - 1) ? '0 : PTR_W'(idx + 1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_ptr_next;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_valid[i]) begin
                found    = 1'b1;
                idx      = i;
                grant[i] = enable;
            end
        end
    end
`endif

endmodule

// File: rtl/regfile_write_ctrl.sv
// Register-file write-port controller: arbitration, busy scoreboard and a clean
// one-cycle write strobe. Optional macro: REGFILE_WRITE_CTRL_ROUND_ROBIN_EN.
module regfile_write_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int XLEN       = regfile_ctrl_pkg::XLEN,
    parameter int REG_ADDR_W = regfile_ctrl_pkg::REG_ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*REG_ADDR_W-1:0] req_reg,
    input  logic [N_REQ*XLEN-1:0]       req_data,
    output logic [N_REQ-1:0]            req_ready,
    input  logic                        issue_valid,
    input  logic [REG_ADDR_W-1:0]       issue_reg,
    input  logic [REG_ADDR_W-1:0]       query_reg1,
    input  logic [REG_ADDR_W-1:0]       query_reg2,
    output logic                        query_busy1,
    output logic                        query_busy2,
    output logic [REG_ADDR_W-1:0]       write_reg,
    output logic [XLEN-1:0]             write_data,
    output logic                        write_enable,
    output logic                        sb_err,
    output logic [1:0]                  state_dbg
);

    localparam int NREG = 1 << REG_ADDR_W;

    // Handshake: requester i transfers on a clk edge where req_valid[i] && req_ready[i];
    // it must hold valid, reg and data stable until that edge.

    wr_state_t              state;
    wr_state_t              state_next;
    logic                   grant_allowed;
    logic [N_REQ-1:0]       grant;
    logic                   any_grant;
    logic [REG_ADDR_W-1:0]  win_reg;
    logic [XLEN-1:0]        win_data;
    logic [NREG-1:0]        busy;
    logic [NREG-1:0]        busy_next;
    logic                   set_en;
    logic                   clr_en;
    logic                   err_set;

    wb_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .enable    (grant_allowed),
        .grant     (grant)
    );

    assign req_ready = grant;
    assign any_grant = |grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = any_grant ? SETUP : IDLE;
            SETUP:   state_next = STROBE;
            STROBE:  state_next = any_grant ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grant_allowed = (state == IDLE) || (state == STROBE);
        state_dbg     = state;
    end

    always_comb begin
        win_reg  = '0;
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                win_reg  = req_reg[i*REG_ADDR_W +: REG_ADDR_W];
                win_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // Strobe is raised one cycle after the load so address/data have a full cycle of setup;
    // writes to x0 sequence normally but never produce an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_reg    <= '0;
            write_data   <= '0;
            write_enable <= 1'b0;
        end else begin
            if (any_grant) begin
                write_reg  <= win_reg;
                write_data <= win_data;
            end
            write_enable <= (state == SETUP) && (write_reg != '0);
        end
    end

    // Clear happens on the SETUP->STROBE edge; a same-edge issue to that register wins.
    always_comb begin
        busy_next = busy;
        set_en    = issue_valid && (issue_reg != '0);
        clr_en    = (state == SETUP);
        if (clr_en) begin
            busy_next[write_reg] = 1'b0;
        end
        if (set_en) begin
            busy_next[issue_reg] = 1'b1;
        end
        busy_next[0] = 1'b0;
        err_set = set_en && busy[issue_reg] && !(clr_en && (write_reg == issue_reg));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= '0;
            sb_err <= 1'b0;
        end else begin
            busy <= busy_next;
            if (err_set) begin
                sb_err <= 1'b1;
            end
        end
    end

    assign query_busy1 = busy[query_reg1];
    assign query_busy2 = busy[query_reg2];

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Bench for regfile_write_ctrl: directed test-plan scenarios plus random traffic,
// checked against a cycle-level behavioural model and an expected-write queue.
module tb_regfile_write_ctrl;
    import regfile_ctrl_pkg::*;

    localparam int N  = 2;
    localparam int RW = 5;
    localparam int DW = 32;
    localparam int EW = 32 + RW + DW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*RW-1:0] req_reg = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            issue_valid = 1'b0;
    logic [RW-1:0]   issue_reg = '0;
    logic [RW-1:0]   query_reg1 = '0;
    logic [RW-1:0]   query_reg2 = '0;
    logic            query_busy1;
    logic            query_busy2;
    logic [RW-1:0]   write_reg;
    logic [DW-1:0]   write_data;
    logic            write_enable;
    logic            sb_err;
    logic [1:0]      state_dbg;

    regfile_write_ctrl #(.N_REQ(N), .XLEN(DW), .REG_ADDR_W(RW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data), .req_ready(req_ready),
        .issue_valid(issue_valid), .issue_reg(issue_reg),
        .query_reg1(query_reg1), .query_reg2(query_reg2),
        .query_busy1(query_busy1), .query_busy2(query_busy2),
        .write_reg(write_reg), .write_data(write_data), .write_enable(write_enable),
        .sb_err(sb_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned cyc = 0;

    // Requester-side holding registers and the behavioural model.
    bit            h_valid[N];
    logic [RW-1:0] h_reg[N];
    logic [DW-1:0] h_data[N];
    bit            m_blocked;
    bit            m_busy[32];
    bit            m_err;
    int            m_ptr;
    bit            pend_valid;
    logic [RW-1:0] pend_reg;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Whichever valid requester the policy prefers, or -1 if none.
    function automatic int pick();
        int i;
`ifdef REGFILE_WRITE_CTRL_ROUND_ROBIN_EN
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (h_valid[i]) return i;
        end
`else
        for (i = 0; i < N; i++) begin
            if (h_valid[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_blocked  = 1'b0;
        m_err      = 1'b0;
        m_ptr      = 0;
        pend_valid = 1'b0;
        pend_reg   = '0;
        for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
    endtask

    // One clock cycle: drive, check combinational/registered outputs, advance model.
    task automatic step(input bit do_rst, input bit iv, input logic [RW-1:0] ireg,
                        input logic [RW-1:0] q1, input logic [RW-1:0] q2);
        int w;
        logic [N-1:0] exp_ready;
        bit gnt;
        bit set;
        @(posedge clk);
        #1;
        cyc++;
        rst = do_rst;
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = h_valid[i] && !do_rst;
            req_reg[i*RW +: RW]   = h_reg[i];
            req_data[i*DW +: DW]  = h_data[i];
        end
        issue_valid = iv && !do_rst;
        issue_reg   = ireg;
        query_reg1  = q1;
        query_reg2  = q2;
        #3;
        w = do_rst ? -1 : pick();
        gnt = !m_blocked && (w >= 0);
        exp_ready = '0;
        if (gnt) exp_ready[w] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("query_busy1", 64'(query_busy1), 64'(m_busy[q1]));
        check("query_busy2", 64'(query_busy2), 64'(m_busy[q2]));
        check("sb_err", 64'(sb_err), 64'(m_err));
        if (do_rst) begin
            model_reset();
            while (exp_q.size() > 0 && exp_q[exp_q.size()-1][EW-1 -: 32] > cyc)
                void'(exp_q.pop_back());
        end else begin
            set = iv && (ireg != 0);
            if (set && m_busy[ireg] && !(pend_valid && pend_reg == ireg)) m_err = 1'b1;
            if (pend_valid) m_busy[pend_reg] = 1'b0;
            if (set) m_busy[ireg] = 1'b1;
            m_busy[0] = 1'b0;
            pend_valid = gnt;
            if (gnt) begin
                pend_reg = h_reg[w];
                if (h_reg[w] != 0) exp_q.push_back({32'(cyc + 2), h_reg[w], h_data[w]});
                h_valid[w] = 1'b0;
                m_ptr = (w + 1) % N;
            end
            m_blocked = gnt;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, 5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)));
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) h_valid[i] = 1'b0;
        step(1'b1, 1'b0, '0, '0, '0);
    endtask

    task automatic check_zero();
        check("rst_write_enable", 64'(write_enable), 64'(0));
        check("rst_write_reg", 64'(write_reg), 64'(0));
        check("rst_write_data", 64'(write_data), 64'(0));
        check("rst_sb_err", 64'(sb_err), 64'(0));
        check("rst_state", 64'(state_dbg), 64'(IDLE));
    endtask

    // Monitor: every write_enable must match the head of the expected-write queue.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (exp_q.size() > 0 && exp_q[0][EW-1 -: 32] < cyc) begin
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL write_missed: cycle %0d got no strobe expected reg %0d data %0h at cycle %0d",
                     cyc, e[DW +: RW], e[DW-1:0], e[EW-1 -: 32]);
        end
        if (write_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL write_spurious: cycle %0d got strobe reg %0d data %0h expected none",
                         cyc, write_reg, write_data);
            end else begin
                e = exp_q.pop_front();
                check("write_cycle", 64'(cyc), 64'(e[EW-1 -: 32]));
                check("write_reg", 64'(write_reg), 64'(e[DW +: RW]));
                check("write_data", 64'(write_data), 64'(e[DW-1:0]));
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            h_valid[i] = 1'b0;
            h_reg[i]   = '0;
            h_data[i]  = '0;
        end
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);

        // Reset state.
        idle(1);
        check_zero();

        // Single write to r5 after issuing r5.
        step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0);
        h_valid[0] = 1'b1; h_reg[0] = 5'd5; h_data[0] = 32'hDEADBEEF;
        step(1'b0, 1'b0, '0, 5'd5, 5'd5);
        step(1'b0, 1'b0, '0, 5'd5, 5'd5);
        check("setup_write_reg", 64'(write_reg), 64'(5));
        idle(3);

        // Both requesters continuously valid.
        for (int k = 0; k < 12; k++) begin
            if (!h_valid[0]) begin h_valid[0] = 1'b1; h_reg[0] = 5'd3; h_data[0] = $urandom; end
            if (!h_valid[1]) begin h_valid[1] = 1'b1; h_reg[1] = 5'd4; h_data[1] = $urandom; end
            step(1'b0, 1'b0, '0, 5'd3, 5'd4);
        end
        do_reset();
        idle(2);

        // Scoreboard: set, same-edge set/clear, then WAW error.
        step(1'b0, 1'b1, 5'd7, 5'd7, 5'd0);
        h_valid[0] = 1'b1; h_reg[0] = 5'd7; h_data[0] = 32'h0000_0777;
        step(1'b0, 1'b0, '0, 5'd7, 5'd7);
        step(1'b0, 1'b1, 5'd7, 5'd7, 5'd7);
        step(1'b0, 1'b0, '0, 5'd7, 5'd7);
        step(1'b0, 1'b1, 5'd7, 5'd7, 5'd7);
        idle(3);
        do_reset();
        idle(1);

        // Write to x0 is consumed without a strobe.
        h_valid[0] = 1'b1; h_reg[0] = 5'd0; h_data[0] = 32'h1;
        idle(4);

        // Reset during SETUP drops the in-flight write.
        h_valid[0] = 1'b1; h_reg[0] = 5'd9; h_data[0] = 32'h0BAD_F00D;
        step(1'b0, 1'b1, 5'd9, 5'd9, 5'd0);
        step(1'b1, 1'b0, '0, 5'd9, 5'd0);
        step(1'b0, 1'b0, '0, 5'd9, 5'd0);
        check_zero();
        idle(2);

        // Request arriving during SETUP waits for STROBE.
        h_valid[0] = 1'b1; h_reg[0] = 5'd10; h_data[0] = 32'hA0A0_A0A0;
        step(1'b0, 1'b0, '0, 5'd10, 5'd11);
        h_valid[1] = 1'b1; h_reg[1] = 5'd11; h_data[1] = 32'hB1B1_B1B1;
        idle(5);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(59, 0) == 0) begin
                do_reset();
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (!h_valid[i] && $urandom_range(1, 0) == 1) begin
                        h_valid[i] = 1'b1;
                        h_reg[i]   = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
                        h_data[i]  = $urandom;
                    end
                end
                step(1'b0, ($urandom_range(7, 0) == 0), 5'($urandom_range(31, 0)),
                     5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)));
            end
        end

        for (int i = 0; i < N; i++) h_valid[i] = 1'b0;
        idle(4);
        check("exp_q_drained", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
